decoder_scan_sequencer: RTL
===========================

// Module: decoder_scan_sequencer
// PURPOSE
//  Timed channel scanner that drives the 2-bit select and enable of a downstream 2x4 enable decoder.
//  Visits channels 0..3 in order. Holds each channel active for a programmable dwell, then blanks for a fixed gap.
//  Runs frames continuously until stopped; signals the end of every frame. Typical use: 4-digit display or 4-way strobe scan.
// PARAMETERS
//  DWELL_W    8  width of dwell input; dwell = number of cycles sel_en is high per channel
//  BLANK_CYC  2  cycles of sel_en=0 between channels (0 = no gap, back-to-back channels)
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  start       in   1        1-cycle request to begin scanning (sampled in IDLE only)
//  stop        in   1        request to halt at the end of the current frame
//  dwell       in   DWELL_W  active cycles per channel, sampled on each channel entry; 0 treated as 1
//  skip_mask   in   4        [i]=1 skips channel i (present only with DEC_SCAN_SKIP_EN)
//  sel         out  2        channel index, drives decoder w
//  sel_en      out  1        drives decoder en; 1 only while the channel is active
//  busy        out  1        1 from first active cycle until return to IDLE
//  frame_done  out  1        1-cycle pulse at end of each frame
// BEHAVIOUR
//  All outputs registered. Reset (async assert, sync deassert upstream): sel=0, sel_en=0, busy=0, frame_done=0; state=IDLE; stop_pend=0; cnt=0.
//  FSM states IDLE, DWELL, BLANK.
//  IDLE: start=1 and stop=0 -> DWELL on first channel. sel_en=1 and busy=1 in the cycle after start (latency 1). Otherwise remain in IDLE.
//  DWELL entry: sel=channel; sel_en=1; cnt=max(dwell,1)-1. Each cycle: cnt!=0 -> decrement; cnt==0 -> leave channel.
//    Result: sel_en is high exactly max(dwell,1) cycles per channel.
//  Leaving a channel:
//    Not the frame's last channel: BLANK_CYC>0 -> BLANK (cnt=BLANK_CYC-1, sel_en=0, sel holds outgoing channel); else go directly to the next channel's DWELL.
//    Last channel and stop_pend=1: go to IDLE. No trailing blank. sel_en=0, busy=0, stop_pend cleared.
//    Last channel and stop_pend=0: BLANK (if BLANK_CYC>0), then wrap to channel 0 of a new frame.
//  frame_done=1 for exactly the one cycle after the last sel_en-high cycle of the frame's final channel. That cycle is the first BLANK cycle, the first cycle of the next frame, or the first IDLE cycle.
//  BLANK: cnt counts down to 0, then enters the next channel's DWELL. Channel order wraps 3->0.
//  stop: any stop=1 while busy sets stop_pend. stop in IDLE is ignored. start while busy is ignored. start and stop in the same IDLE cycle: stay IDLE.
//  dwell changes take effect only at the next channel entry.
//  Async reset mid-operation: outputs drop immediately to reset values. The scan does not resume; a new start is required.
// CONFIGURATION
//  Macro DEC_SCAN_SKIP_EN.
//  Defined: skip_mask port exists. Mask is sampled at frame start (start acceptance and each wrap).
//    Masked channels are skipped with no dwell and no blank. Last channel = highest unmasked index.
//    start with skip_mask=4'b1111 is ignored. An all-ones mask sampled at wrap -> IDLE (frame_done already pulsed).
//  Undefined: no skip_mask port; all four channels are scanned every frame.
// STRUCTURE
//  Shared package dec_scan_pkg:
//    state typedef {IDLE, DWELL, BLANK}
//    localparams N_CH=4, SEL_W=2
//    function next_ch(cur, mask) -> next unmasked index plus a wrap flag.
//  One sub-module: dec_scan_timer. Loadable down-counter, DWELL_W wide, with load, load value, and zero flag. Used for both dwell and blank.
//  The top holds the FSM, sel/stop_pend registers and output registers. Instantiate alongside decoder_2x4_en (sel->w, sel_en->en).
// TESTING (DWELL_W=8, BLANK_CYC=2 unless stated)
//  1 dwell=3, start pulse, no stop:
//    sel 0,1,2,3 each with sel_en=1 for 3 cycles, separated by 2 sel_en=0 cycles.
//    frame_done every 20 cycles. Decoder y = 1000,0100,0010,0001 in turn.
//  2 dwell=0, BLANK_CYC=0:
//    sel_en constantly 1; sel steps 0,1,2,3 every cycle.
//    frame_done every 4 cycles.
//  3 dwell=2, stop pulse while sel=1:
//    channels 2 and 3 complete. Next cycle: frame_done=1, busy=0, sel_en=0. No further channel activity.
//  4 start and stop in the same IDLE cycle:
//    busy stays 0 and sel_en stays 0. A later start alone begins the scan with 1-cycle latency.
//  5 rst_n low mid-DWELL on sel=2:
//    sel=0, sel_en=0, busy=0 immediately. After release, outputs stay idle until start.
//  6 DEC_SCAN_SKIP_EN, skip_mask=4'b1010, dwell=1:
//    sel sequence 0,2,0,2; frame_done after each ch2 dwell.
//    Mask 4'b1111 at start: no activity.

Source files
------------

// File: rtl/dec_scan_pkg.sv
// Shared types and helpers for the decoder scan sequencer.
// The channel-skip feature is enabled by defining DEC_SCAN_SKIP_EN.
package dec_scan_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    BLANK
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0] ch;    // next channel to visit
    logic             wrap;  // no unmasked channel above cur: next visit starts a new frame
  } next_ch_t;

  // Next unmasked channel after cur. When nothing above cur is unmasked,
  // the result is the lowest unmasked channel and wrap is set.
  function automatic next_ch_t next_ch(input logic [SEL_W-1:0] cur,
                                       input logic [N_CH-1:0]  mask);
    next_ch_t r;
    r.ch   = '0;
    r.wrap = 1'b1;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i > int'(cur) && !mask[i]) begin
        r.ch   = SEL_W'(i);
        r.wrap = 1'b0;
      end
    end
    if (r.wrap) begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (!mask[i]) r.ch = SEL_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_scan_sequencer_if.sv
// Control/status bundle of the decoder scan sequencer.
// skip_mask exists only when DEC_SCAN_SKIP_EN is defined.
interface decoder_scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic [DWELL_W-1:0] dwell;
`ifdef DEC_SCAN_SKIP_EN
  logic [3:0]         skip_mask;
`endif
  logic [1:0]         sel;
  logic               sel_en;
  logic               busy;
  logic               frame_done;

`ifdef DEC_SCAN_SKIP_EN
  modport master (output start, stop, dwell, skip_mask,
                  input  sel, sel_en, busy, frame_done);
  modport slave  (input  start, stop, dwell, skip_mask,
                  output sel, sel_en, busy, frame_done);
`else
  modport master (output start, stop, dwell,
                  input  sel, sel_en, busy, frame_done);
  modport slave  (input  start, stop, dwell,
                  output sel, sel_en, busy, frame_done);
`endif
endinterface

// File: rtl/dec_scan_timer.sv
// Loadable down-counter shared by the dwell and blank phases.
// Counts down to zero and holds there until the next load.
module dec_scan_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority; otherwise decrement until zero is reached.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/decoder_2x4_en.sv
// 2-to-4 enable decoder driven by the scan sequencer.
// y is written MSB-first by channel: w=0 asserts y[3], w=3 asserts y[0].
module decoder_2x4_en (
  input  logic [1:0] w,
  input  logic       en,
  output logic [3:0] y
);

  assign y = en ? (4'b1000 >> w) : 4'b0000;

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Timed channel scanner for a 2x4 enable decoder: visits channels in order,
// holds each for a programmable dwell, blanks BLANK_CYC cycles between them,
// and pulses frame_done at the end of every frame.
// Define DEC_SCAN_SKIP_EN to add a per-frame channel skip mask.
module decoder_scan_sequencer
  import dec_scan_pkg::*;
#(
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 2
) (
  input logic                        clk,
  input logic                        rst_n,
  decoder_scan_sequencer_if.slave    bus
);

  localparam logic [DWELL_W-1:0] BLANK_LOAD =
    (BLANK_CYC > 0) ? DWELL_W'(BLANK_CYC - 1) : '0;

  state_t             state_q, state_nxt;
  logic [SEL_W-1:0]   sel_q, sel_nxt;
  logic [N_CH-1:0]    mask_q, mask_nxt;
  logic               stop_pend_q, stop_pend_nxt;
  logic               fd_nxt;
  logic               sel_en_q, busy_q, fd_q;

  logic               t_load, t_zero;
  logic [DWELL_W-1:0] t_val, dwell_load;
  logic [N_CH-1:0]    live_mask;
  logic               live_empty;
  logic               leave;
  next_ch_t           nc, first;

`ifdef DEC_SCAN_SKIP_EN
  assign live_mask = bus.skip_mask;
`else
  assign live_mask = '0;
`endif

  assign live_empty = &live_mask;
  assign dwell_load = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
  assign nc         = next_ch(sel_q, mask_q);
  assign first      = next_ch(SEL_W'(N_CH - 1), live_mask);

  dec_scan_timer #(.W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  // Next-state, channel advance and frame bookkeeping.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt     = state_q;
    sel_nxt       = sel_q;
    mask_nxt      = mask_q;
    stop_pend_nxt = stop_pend_q | ((state_q != IDLE) & bus.stop);
    fd_nxt        = 1'b0;
    t_load        = 1'b0;
    t_val         = dwell_load;
    leave         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && !live_empty) begin
          state_nxt     = DWELL;
          sel_nxt       = first.ch;
          mask_nxt      = live_mask;
          t_load        = 1'b1;
          stop_pend_nxt = 1'b0;
        end
      end
      DWELL: begin
        if (t_zero) begin
          fd_nxt = nc.wrap;
          if (nc.wrap && stop_pend_q) begin
            state_nxt     = IDLE;
            stop_pend_nxt = 1'b0;
          end else if (BLANK_CYC > 0) begin
            state_nxt = BLANK;
            t_load    = 1'b1;
            t_val     = BLANK_LOAD;
          end else begin
            leave = 1'b1;
          end
        end
      end
      BLANK: begin
        if (t_zero) leave = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Enter the next channel; a wrap starts a new frame with a fresh mask.
    if (leave) begin
      if (!nc.wrap) begin
        state_nxt = DWELL;
        sel_nxt   = nc.ch;
        t_load    = 1'b1;
      end else if (live_empty) begin
        state_nxt     = IDLE;
        stop_pend_nxt = 1'b0;
      end else begin
        state_nxt = DWELL;
        sel_nxt   = first.ch;
        mask_nxt  = live_mask;
        t_load    = 1'b1;
      end
    end
  end

  // State, channel and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      mask_q      <= '0;
      stop_pend_q <= 1'b0;
      sel_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      sel_q       <= sel_nxt;
      mask_q      <= mask_nxt;
      stop_pend_q <= stop_pend_nxt;
      sel_en_q    <= (state_nxt == DWELL);
      busy_q      <= (state_nxt != IDLE);
      fd_q        <= fd_nxt;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.sel_en     = sel_en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = fd_q;

endmodule
